lovers_mult_arbiter: RTL and testbench

- Shares one GF(2^163) interleaved multiplier (`interleaved_mult`) among N_REQ requesters in the lovers_bec datapath, e.g. point-add and point-double sequencers.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the multiplier's start/done handshake.
- Returns the product to the winner on a shared response channel tagged with the requester index.
- A watchdog aborts a multiplication that never completes.

---
 rtl/lovers_bec_pkg.sv | 15 +
 rtl/lovers_rr_arbiter.sv | 34 +++
 rtl/lovers_mult_arbiter.sv | 160 ++++++++++++++++
 tb/tb_lovers_mult_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lovers_bec_pkg.sv
// Shared constants and types for the lovers_bec GF(2^163) datapath.
package lovers_bec_pkg;

    localparam int M               = 163;
    localparam logic [M-1:0] GF_RED_POLY = 163'hC9;   // x^163 = x^7 + x^6 + x^3 + 1
    localparam int N_REQ_DEF       = 4;
    localparam int TIMEOUT_CYC_DEF = 400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/lovers_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above rr_ptr, wrapping.
module lovers_rr_arbiter
    import lovers_bec_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       grant_idx
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [3:0] pos;
    logic       found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, rr_ptr} + 4'(k);
            if (pos >= 4'(N_REQ)) pos = pos - 4'(N_REQ);
            if (!found && req[pos[IW-1:0]]) begin
                found               = 1'b1;
                grant[pos[IW-1:0]]  = 1'b1;
                grant_idx           = 3'(pos);
            end
        end
    end

endmodule

// File: rtl/lovers_mult_arbiter.sv
// Shares one GF(2^163) interleaved multiplier among N_REQ requesters with
// round-robin grant, start/done sequencing, tagged response and watchdog abort.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for any req_valid; grants and launches at the edge
//   BUSY    | mul_start held, waiting for mul_done or watchdog expiry
//   RESP    | response held on rsp_* until rsp_ready; mul_start low
module lovers_mult_arbiter
    import lovers_bec_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int M           = lovers_bec_pkg::M,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*M-1:0] req_a,
    input  logic [N_REQ*M-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [2:0]         rsp_id,
    output logic [M-1:0]       rsp_z,
    output logic               rsp_err,
    input  logic               rsp_ready,
    output logic [M-1:0]       mul_a,
    output logic [M-1:0]       mul_b,
    output logic               mul_start,
    input  logic [M-1:0]       mul_z,
    input  logic               mul_done
);

    localparam int WW = $clog2(TIMEOUT_CYC) + 1;

    arb_state_t       state_q, state_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [2:0]       rsp_id_q, rsp_id_d;
    logic [M-1:0]     rsp_z_q, rsp_z_d;
    logic             rsp_err_q, rsp_err_d;
    logic             mul_start_q, mul_start_d;
    logic [M-1:0]     mul_a_q, mul_a_d;
    logic [M-1:0]     mul_b_q, mul_b_d;

    logic [N_REQ-1:0] grant;
    logic [2:0]       grant_idx;
    logic [M-1:0]     sel_a, sel_b;

    lovers_rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*M +: M];
                sel_b = req_b[i*M +: M];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        wdog_d      = wdog_q;
        req_ready_d = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        rsp_err_d   = rsp_err_q;
        mul_start_d = mul_start_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready_d = grant;
                    mul_a_d     = sel_a;
                    mul_b_d     = sel_b;
                    rsp_id_d    = grant_idx;
                    mul_start_d = 1'b1;
                    wdog_d      = '0;
                    rr_ptr_d    = (grant_idx == 3'(N_REQ-1)) ? 3'd0 : grant_idx + 3'd1;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A completion on the expiry cycle still counts as success.
                if (mul_done) begin
                    rsp_z_d     = mul_z;
                    rsp_err_d   = 1'b0;
                    mul_start_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (wdog_q == WW'(TIMEOUT_CYC-1)) begin
                    rsp_z_d     = '0;
                    rsp_err_d   = 1'b1;
                    mul_start_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            wdog_q      <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
            rsp_err_q   <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            wdog_q      <= wdog_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            rsp_err_q   <= rsp_err_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_err   = rsp_err_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_lovers_mult_arbiter.sv
// Directed bench for lovers_mult_arbiter with a behavioural fixed-latency multiplier stub.
module tb_lovers_mult_arbiter;

    localparam int NR  = 4;
    localparam int MW  = 163;
    localparam int TO  = 400;
    localparam int LAT = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*MW-1:0]  req_a = '0;
    logic [NR*MW-1:0]  req_b = '0;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic [2:0]        rsp_id;
    logic [MW-1:0]     rsp_z;
    logic              rsp_err;
    logic              rsp_ready = 1'b0;
    logic [MW-1:0]     mul_a, mul_b;
    logic              mul_start;
    logic [MW-1:0]     mul_z = '0;
    logic              mul_done = 1'b0;

    logic              stub_en = 1'b1;
    int                stub_cnt = 0;
    int                checks = 0;
    int                failures = 0;

    lovers_mult_arbiter #(.N_REQ(NR), .M(MW), .TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_z     (mul_z),
        .mul_done  (mul_done)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] gf_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] r;
        logic [MW-1:0] x;
        logic          c;
        r = '0;
        x = a;
        for (int i = 0; i < MW; i++) begin
            if (b[i]) r = r ^ x;
            c = x[MW-1];
            x = x << 1;
            if (c) x = x ^ 163'hC9;
        end
        return r;
    endfunction

    // Multiplier stub: mul_done pulses LAT cycles after mul_start is first seen high.
    always @(posedge clk) begin
        if (!mul_start) begin
            stub_cnt <= 0;
            mul_done <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
            mul_done <= stub_en && (stub_cnt == LAT-1);
            if (stub_en && stub_cnt == LAT-1) mul_z <= gf_mul(mul_a, mul_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [MW-1:0] a, input logic [MW-1:0] b);
        req_a[i*MW +: MW] = a;
        req_b[i*MW +: MW] = b;
    endtask

    function automatic logic [MW-1:0] op_a(input int i);
        return req_a[i*MW +: MW];
    endfunction

    function automatic logic [MW-1:0] op_b(input int i);
        return req_b[i*MW +: MW];
    endfunction

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 600) begin
            step();
            n++;
        end
    endtask

    // Single request from id; checks grant, latency and response, then completes the handshake.
    task automatic serve(input int id, input logic [MW-1:0] exp_z, input logic exp_err, input int exp_lat);
        int n;
        req_valid = 4'b0001 << id;
        step();
        check("grant_onehot", req_ready, 4'b0001 << id);
        check("start_in_busy", mul_start, 1'b1);
        req_valid = '0;
        wait_rsp(n);
        check("rsp_valid", rsp_valid, 1'b1);
        check("latency", n, exp_lat);
        check("rsp_id", rsp_id, id);
        check("rsp_z", rsp_z, exp_z);
        check("rsp_err", rsp_err, exp_err);
        check("start_low_in_resp", mul_start, 1'b0);
        rsp_ready = 1'b1;
        step();
        check("rsp_released", rsp_valid, 1'b0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int bad;
        int exp_id;

        // Reset values
        step();
        step();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_z", rsp_z, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        rst_n = 1'b1;
        step();

        // Single request, 1*1 = 1
        set_op(0, 163'd1, 163'd1);
        serve(0, 163'd1, 1'b0, LAT+1);

        // Reduction x * x^162 = x^163 = 0xC9, with backpressure
        set_op(2, 163'd2, 163'd1 << 162);
        req_valid = 4'b0100;
        step();
        check("red_grant", req_ready, 4'b0100);
        req_valid = '0;
        wait_rsp(n);
        check("red_rsp_valid", rsp_valid, 1'b1);
        check("red_rsp_id", rsp_id, 2);
        check("red_rsp_z", rsp_z, 163'hC9);
        check("red_rsp_err", rsp_err, 1'b0);
        set_op(3, (163'd5 << 158) ^ 163'h1234_5678_9abc_def0, (163'd3 << 160) ^ 163'hfedc_ba98);
        req_valid = 4'b1000;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_z !== 163'hC9 || rsp_id !== 3'd2 ||
                req_ready !== 4'b0000 || mul_start !== 1'b0) bad++;
        end
        check("bp_stable_cycles_bad", bad, 0);
        rsp_ready = 1'b1;
        step();
        check("bp_accept", rsp_valid, 1'b0);
        check("no_grant_on_hs_edge", req_ready, 4'b0000);
        rsp_ready = 1'b0;
        step();
        check("b2b_grant", req_ready, 4'b1000);
        req_valid = '0;
        wait_rsp(n);
        check("b2b_rsp_id", rsp_id, 3);
        check("b2b_rsp_z", rsp_z, gf_mul(op_a(3), op_b(3)));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Round-robin with all requesters held active
        set_op(0, (163'd7 << 156) ^ 163'h0bad_cafe, 163'h1_0000_0001);
        set_op(1, 163'h8000_0000_0000_0003, (163'd1 << 162) ^ 163'd1);
        set_op(2, (163'd1 << 150) ^ 163'h55, 163'hdead_beef_0123);
        set_op(3, 163'h3, (163'd6 << 157) ^ 163'h77);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % 4;
            n = 0;
            while (req_ready === '0 && n < 50) begin
                step();
                n++;
            end
            check("rr_grant", req_ready, 4'b0001 << exp_id);
            wait_rsp(n);
            if (k == 4) req_valid = '0;
            check("rr_rsp_id", rsp_id, exp_id);
            check("rr_rsp_z", rsp_z, gf_mul(op_a(exp_id), op_b(exp_id)));
        end
        step();
        rsp_ready = 1'b0;
        step();
        check("rr_quiet_after", req_ready, 4'b0000);

        // Watchdog abort on requester 1, then a normal operation on requester 2
        stub_en = 1'b0;
        set_op(1, 163'h1234, 163'h5678);
        serve(1, 163'd0, 1'b1, TO);
        stub_en = 1'b1;
        set_op(2, (163'd3 << 159) ^ 163'hface, 163'h9_0000_0000_0021);
        serve(2, gf_mul(op_a(2), op_b(2)), 1'b0, LAT+1);

        // Async reset 50 cycles into BUSY
        stub_en = 1'b0;
        req_valid = 4'b0010;
        step();
        check("pre_rst_grant", req_ready, 4'b0010);
        req_valid = '0;
        repeat (49) step();
        check("pre_rst_busy", mul_start, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mul_start", mul_start, 1'b0);
        check("arst_mul_a", mul_a, 0);
        check("arst_rsp_valid", rsp_valid, 1'b0);
        check("arst_rsp_id", rsp_id, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        stub_en = 1'b1;
        step();
        step();
        check("no_rsp_after_rst", rsp_valid, 1'b0);
        set_op(1, 163'h3, 163'h5);
        set_op(3, 163'h7, 163'h9);
        req_valid = 4'b1010;
        step();
        check("post_rst_rr_from_0", req_ready, 4'b0010);
        req_valid = '0;
        wait_rsp(n);
        check("post_rst_rsp_id", rsp_id, 1);
        check("post_rst_rsp_z", rsp_z, 163'hF);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
